hdr_lookup_ctrl: RTL and testbench
==================================

Name: hdr_lookup_ctrl

Overview:
Upstream stage of the binary-CAM route table. It takes each incoming frame as a byte stream and extracts the 32-bit IPv4 destination address at a fixed byte offset. It issues one CAM match per frame, captures the hit flag and the entry index, and presents the result on a valid/ready interface to the forwarding-decision logic.

Parameters:
DST_OFFSET, 30, byte offset of the first (MSB) destination-address byte within the frame (14-byte Ethernet header + 16).
KEY_W, 32, CAM key width; fixed at 32; other values unsupported.
MEMDBITS, 9, CAM index width.
CNT_W, 16, byte-counter width; the counter saturates at all-ones.

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
s_tdata  in  8  frame byte
s_tvalid  in  1  byte valid
s_tlast  in  1  last byte of frame
s_tready  out  1  byte accepted when s_tvalid&s_tready
cam_match_en  out  1  one-cycle match strobe to CAM
cam_key  out  KEY_W  key presented with cam_match_en
cam_match  in  1  CAM hit, registered, valid the cycle after the strobe
cam_match_addr  in  MEMDBITS  CAM hit position, 1-based (entry index + 1)
res_valid  out  1  lookup result available
res_ready  in  1  consumer accepts result
res_hit  out  1  1 = key found
res_index  out  MEMDBITS  0-based entry index (cam_match_addr-1); 0 on miss
res_key  out  KEY_W  extracted key

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter 0; key 0. Reset mid-frame discards the frame. The next accepted byte after reset is byte 0 of a new frame; there is no resynchronisation.
- States: IDLE, HDR, DRAIN, LOOKUP, WAIT, RESP.
- s_tready = 1 in IDLE, HDR and DRAIN; 0 otherwise. Frames stall while a lookup is in progress.
- IDLE: the first accepted byte is byte 0; go to HDR. If that byte also has tlast, treat it as a runt.
- HDR: each accepted byte increments the counter. Bytes DST_OFFSET..DST_OFFSET+3 shift into the key big-endian (first byte lands in key[31:24]).
  - After the 4th key byte: go to LOOKUP if that byte has tlast, else go to DRAIN.
  - tlast before the key is complete = runt: no lookup, no result, return to IDLE.
- DRAIN: accept bytes until tlast, then go to LOOKUP.
- LOOKUP: assert cam_match_en=1 with cam_key=key for exactly one cycle, then go to WAIT.
  - Exception: if key==32'hFFFFFFFF (the empty-entry marker), skip the CAM, load res_hit=0, res_index=0, and go directly to RESP.
- WAIT: one cycle. Sample cam_match and cam_match_addr at the end of this cycle.
  - res_hit=cam_match.
  - res_index = cam_match ? cam_match_addr-1 (MEMDBITS-bit wrap) : 0.
  - Go to RESP.
- RESP: res_valid=1. res_hit, res_index and res_key are held stable until res_ready. Go to IDLE on the handshake cycle.
- cam_match_en is 0 in every state except LOOKUP, which guarantees the CAM sees match_en low between lookups.
- Latency: from the tlast-byte handshake to res_valid is 3 cycles (LOOKUP, WAIT, RESP entry); 2 cycles on the invalid-key bypass.
- Throughput: at most one frame per (frame length + 3 + response-wait) cycles.
- Byte counter saturates; frames longer than 2^CNT_W-1 bytes drain correctly.
- The byte counter and key are cleared on return to IDLE.

Optional Feature:
LOOKUP_STATS_EN:
- Defined: adds outputs stat_hit, stat_miss and stat_runt (each 32 bits, saturating, reset 0).
  - stat_hit / stat_miss increment on the RESP handshake according to res_hit; bypassed invalid keys count as misses.
  - stat_runt increments on runt detection.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package lookup_pkg holds:
  - KEY_W;
  - the state enum (IDLE, HDR, DRAIN, LOOKUP, WAIT, RESP);
  - INVALID_KEY = 32'hFFFFFFFF;
  - DEFAULT_DST_OFFSET = 30.
- One natural sub-module: hdr_key_extract. It contains the byte counter, offset compare, key shift register and key_done/runt pulses. The FSM and the CAM/result handshake stay in the top.

Test Plan:
- 64-byte frame, bytes 30..33 = C0 A8 01 05; CAM returns match=1, addr=6 -> cam_match_en for exactly 1 cycle with cam_key=C0A80105; res_valid 3 cycles after tlast; res_hit=1, res_index=5, res_key=C0A80105.
- Same frame, CAM returns match=0 -> res_hit=0, res_index=0; with LOOKUP_STATS_EN, stat_miss=1.
- 20-byte frame (runt) -> no cam_match_en, no res_valid, state back to IDLE; a following valid frame looks up normally; stat_runt=1.
- Key bytes FF FF FF FF -> cam_match_en never asserted; res_valid 2 cycles after tlast with res_hit=0.
- Hold res_ready=0 for 10 cycles -> res_* stable, s_tready=0, next frame stalled; res_ready=1 -> next frame accepted the following cycle.
- resetn=0 for 1 cycle while in DRAIN (byte 40 of 64) -> all outputs 0 next cycle, no result for the aborted frame; the next byte is counted as byte 0.

Source files
------------

// File: rtl/lookup_pkg.sv
// Shared constants and state encoding for the header-lookup front end of the
// binary-CAM route table.
package lookup_pkg;

    localparam int KEY_W              = 32;
    localparam int DEFAULT_DST_OFFSET = 30;

    // All-ones is the marker the CAM uses for an empty entry, so such a key
    // can never produce a meaningful hit.
    localparam logic [KEY_W-1:0] INVALID_KEY = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_LOOKUP = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

endpackage

// File: rtl/hdr_key_extract.sv
// Byte counter and destination-address shift register.
// Counts accepted bytes of the current frame, shifts the key bytes in
// big-endian order and flags when the key is complete or the frame ended
// before the key could be captured.
module hdr_key_extract #(
    parameter int DST_OFFSET = 30,
    parameter int KEY_W      = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             beat,
    input  logic [7:0]       data,
    input  logic             last,
    output logic [KEY_W-1:0] key,
    output logic             key_done,
    output logic             runt
);

    localparam logic [CNT_W-1:0] KEY_FIRST = CNT_W'(DST_OFFSET);
    localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(DST_OFFSET + KEY_W/8 - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [CNT_W-1:0] cnt;
    logic             in_key;

    assign in_key   = (cnt >= KEY_FIRST) && (cnt <= KEY_LAST);
    assign key_done = beat && (cnt == KEY_LAST);
    // Once the counter has passed the key it only grows or saturates, so a
    // late tlast is never mistaken for a runt.
    assign runt     = beat && last && (cnt < KEY_LAST);

    // Count accepted bytes (saturating) and shift key bytes in MSB first
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            cnt <= '0;
            key <= '0;
        end else if (beat) begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (in_key) begin
                key <= {key[KEY_W-9:0], data};
            end
        end
    end

endmodule

// File: rtl/hdr_lookup_ctrl.sv
// Header lookup controller: extracts the IPv4 destination address from each
// frame, issues one CAM match per frame and returns hit/index/key on a
// valid/ready result port.
// Optional build macro LOOKUP_STATS_EN adds saturating hit/miss/runt counters.
//
//   state  | meaning
//   IDLE   | waiting for byte 0 of a frame
//   HDR    | counting header bytes, capturing the key
//   DRAIN  | key captured, discarding bytes up to tlast
//   LOOKUP | one-cycle CAM match strobe (skipped for the invalid key)
//   WAIT   | CAM result registered, sampled at end of cycle
//   RESP   | result held on res_* until res_ready
module hdr_lookup_ctrl #(
    parameter int DST_OFFSET = lookup_pkg::DEFAULT_DST_OFFSET,
    parameter int KEY_W      = lookup_pkg::KEY_W,
    parameter int MEMDBITS   = 9,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [7:0]          s_tdata,
    input  logic                s_tvalid,
    input  logic                s_tlast,
    output logic                s_tready,
    output logic                cam_match_en,
    output logic [KEY_W-1:0]    cam_key,
    input  logic                cam_match,
    input  logic [MEMDBITS-1:0] cam_match_addr,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_hit,
    output logic [MEMDBITS-1:0] res_index,
    output logic [KEY_W-1:0]    res_key
`ifdef LOOKUP_STATS_EN
    ,
    output logic [31:0]         stat_hit,
    output logic [31:0]         stat_miss,
    output logic [31:0]         stat_runt
`endif
);

    import lookup_pkg::*;

    state_e           state;
    state_e           state_nxt;
    logic             beat;
    logic             key_done;
    logic             runt;
    logic             res_done;
    logic             clr;
    logic             key_invalid;
    logic [KEY_W-1:0] key;

    assign s_tready    = (state == ST_IDLE) || (state == ST_HDR) || (state == ST_DRAIN);
    assign beat        = s_tvalid && s_tready;
    assign res_done    = (state == ST_RESP) && res_ready;
    assign clr         = runt || res_done;
    assign key_invalid = (key == INVALID_KEY);

    assign cam_match_en = (state == ST_LOOKUP) && !key_invalid;
    assign cam_key      = cam_match_en ? key : '0;
    assign res_valid    = (state == ST_RESP);

    hdr_key_extract #(
        .DST_OFFSET (DST_OFFSET),
        .KEY_W      (KEY_W),
        .CNT_W      (CNT_W)
    ) u_extract (
        .clk      (clk),
        .resetn   (resetn),
        .clr      (clr),
        .beat     (beat),
        .data     (s_tdata),
        .last     (s_tlast),
        .key      (key),
        .key_done (key_done),
        .runt     (runt)
    );

    // Next-state decode for the frame/lookup sequence
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (beat && !runt) begin
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (runt) begin
                    state_nxt = ST_IDLE;
                end else if (key_done) begin
                    state_nxt = s_tlast ? ST_LOOKUP : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (beat && s_tlast) begin
                    state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: state_nxt = key_invalid ? ST_RESP : ST_WAIT;
            ST_WAIT:   state_nxt = ST_RESP;
            ST_RESP: begin
                if (res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Result capture: key at LOOKUP, CAM outcome at end of WAIT, held through RESP
    always_ff @(posedge clk) begin
        if (!resetn) begin
            res_hit   <= 1'b0;
            res_index <= '0;
            res_key   <= '0;
        end else begin
            if (state == ST_LOOKUP) begin
                res_key <= key;
                if (key_invalid) begin
                    res_hit   <= 1'b0;
                    res_index <= '0;
                end
            end else if (state == ST_WAIT) begin
                res_hit   <= cam_match;
                res_index <= cam_match ? (cam_match_addr - MEMDBITS'(1)) : '0;
            end
        end
    end

`ifdef LOOKUP_STATS_EN
    // Saturating counters: hit/miss at result handshake, runt at detection
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_hit  <= '0;
            stat_miss <= '0;
            stat_runt <= '0;
        end else begin
            if (res_done) begin
                if (res_hit) begin
                    if (stat_hit != '1) begin
                        stat_hit <= stat_hit + 32'd1;
                    end
                end else if (stat_miss != '1) begin
                    stat_miss <= stat_miss + 32'd1;
                end
            end
            if (runt && (stat_runt != '1)) begin
                stat_runt <= stat_runt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hdr_lookup_ctrl.sv
// Bench for hdr_lookup_ctrl: directed frames followed by randomized frames,
// each checked against expectations derived from frame length, key and the
// planned CAM response. Build with LOOKUP_STATS_EN to also check counters.
module tb_hdr_lookup_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic        cam_match_en;
    logic [31:0] cam_key;
    logic        cam_match;
    logic [8:0]  cam_match_addr;
    logic        res_valid;
    logic        res_ready;
    logic        res_hit;
    logic [8:0]  res_index;
    logic [31:0] res_key;
`ifdef LOOKUP_STATS_EN
    logic [31:0] stat_hit;
    logic [31:0] stat_miss;
    logic [31:0] stat_runt;
`endif

    always #5 clk = ~clk;

    hdr_lookup_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .s_tlast        (s_tlast),
        .s_tready       (s_tready),
        .cam_match_en   (cam_match_en),
        .cam_key        (cam_key),
        .cam_match      (cam_match),
        .cam_match_addr (cam_match_addr),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_hit        (res_hit),
        .res_index      (res_index),
        .res_key        (res_key)
`ifdef LOOKUP_STATS_EN
        ,
        .stat_hit       (stat_hit),
        .stat_miss      (stat_miss),
        .stat_runt      (stat_runt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // model counters
    int m_hit  = 0;
    int m_miss = 0;
    int m_runt = 0;

    // CAM model state
    bit          cam_pend   = 1'b0;
    logic        plan_hit   = 1'b0;
    logic [8:0]  plan_addr  = '0;
    int          strobe_cnt = 0;
    logic [31:0] strobe_key = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registered CAM: result valid only during the cycle after the strobe,
    // random noise otherwise.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cam_pend) begin
                cam_match      = plan_hit;
                cam_match_addr = plan_addr;
                cam_pend       = 1'b0;
            end else begin
                cam_match      = 1'($urandom());
                cam_match_addr = 9'($urandom());
            end
            if (cam_match_en === 1'b1) begin
                cam_pend   = 1'b1;
                strobe_cnt++;
                strobe_key = cam_key;
            end
        end
    end

    // Send one frame starting at a negedge and follow it through the result
    // handshake. Expectations come straight from length/key/CAM plan.
    task automatic run_frame(input int len, input logic [31:0] key, input bit hit,
                             input logic [8:0] addr, input int rwait, input bit gaps);
        bit         runt_f;
        bit         bypass;
        bit         exp_hit;
        logic [8:0] exp_idx;
        int         exp_lat;
        int         lat;
        int         s0;
        logic [31:0] kv;
        logic [7:0] b;

        runt_f  = (len < 34);
        bypass  = !runt_f && (key == 32'hFFFF_FFFF);
        exp_hit = !runt_f && !bypass && hit;
        exp_idx = exp_hit ? addr - 9'd1 : 9'd0;
        exp_lat = bypass ? 2 : 3;
        plan_hit  = hit;
        plan_addr = addr;
        s0 = strobe_cnt;
        kv = key;

        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    s_tvalid = 1'b0;
                    s_tlast  = 1'b0;
                    @(negedge clk);
                end
            end
            if (i >= 30 && i < 34) b = kv[31 - 8*(i-30) -: 8];
            else                   b = 8'($urandom());
            s_tdata  = b;
            s_tvalid = 1'b1;
            s_tlast  = (i == len - 1);
            chk("s_tready_in_frame", s_tready, 1'b1);
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;

        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            if (res_valid === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end

        if (runt_f) begin
            m_runt++;
            chk("runt_no_result", lat, 0);
            chk("runt_no_strobe", strobe_cnt - s0, 0);
            chk("runt_idle_ready", s_tready, 1'b1);
            return;
        end

        chk("latency", lat, exp_lat);
        if (lat == 0) return;

        chk("strobe_count", strobe_cnt - s0, bypass ? 0 : 1);
        if (!bypass) chk("cam_key", strobe_key, key);
        chk("res_hit", res_hit, exp_hit);
        chk("res_index", res_index, exp_idx);
        chk("res_key", res_key, key);
        if (exp_hit) m_hit++;
        else         m_miss++;

        for (int j = 0; j < rwait; j++) begin
            @(negedge clk);
            chk("hold", {res_valid, res_hit, res_index, res_key, s_tready},
                {1'b1, exp_hit, exp_idx, key, 1'b0});
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("after_handshake", {res_valid, s_tready}, 2'b01);
    endtask

    initial begin
        int len;
        logic [31:0] key;

        resetn = 1'b0;
        s_tdata = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        res_ready = 1'b0;
        cam_match = 1'b0;
        cam_match_addr = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {res_valid, cam_match_en, res_hit, res_index, res_key, cam_key}, '0);
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_ready", s_tready, 1'b1);

        // hit, miss, runt then normal, bypass key, long response stall
        run_frame(64, 32'hC0A8_0105, 1'b1, 9'd6, 0, 1'b0);
        run_frame(64, 32'hC0A8_0105, 1'b0, 9'd6, 0, 1'b0);
        run_frame(20, 32'hC0A8_0105, 1'b1, 9'd6, 0, 1'b0);
        run_frame(64, 32'h0A00_0001, 1'b1, 9'd1, 0, 1'b0);
        run_frame(64, 32'hFFFF_FFFF, 1'b1, 9'd3, 0, 1'b0);
        run_frame(34, 32'h1234_5678, 1'b1, 9'd0, 10, 1'b0);
        run_frame(1,  32'h0, 1'b0, 9'd0, 0, 1'b0);
        run_frame(33, 32'hDEAD_BEEF, 1'b1, 9'd2, 0, 1'b0);

        // reset while draining byte 40 of a 64-byte frame
        for (int i = 0; i <= 40; i++) begin
            s_tdata  = 8'($urandom());
            s_tvalid = 1'b1;
            s_tlast  = 1'b0;
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("mid_reset_outputs", {res_valid, cam_match_en, res_hit, res_index, res_key}, '0);
        len = strobe_cnt;
        repeat (5) @(negedge clk);
        chk("mid_reset_no_result", {res_valid, 32'(strobe_cnt - len)}, '0);
        run_frame(64, 32'hC0A8_0105, 1'b1, 9'd6, 0, 1'b0);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 33);
            else                           len = $urandom_range(34, 90);
            if ($urandom_range(0, 5) == 0) key = 32'hFFFF_FFFF;
            else                           key = $urandom();
            run_frame(len, key, 1'($urandom()), 9'($urandom_range(0, 511)),
                      $urandom_range(0, 4), 1'($urandom()));
        end

`ifdef LOOKUP_STATS_EN
        chk("stat_hit", stat_hit, m_hit);
        chk("stat_miss", stat_miss, m_miss);
        chk("stat_runt", stat_runt, m_runt);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
